// File: rtl/vote_arb_pkg.sv
// Shared types and defaults for the vote channel arbiter slice.
package vote_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    REL_RX,
    REL_ST
  } arb_state_e;

  localparam int DEF_N_STATIONS = 4;
  localparam int DEF_DATA_W     = 4;
  localparam int DEF_TIMEOUT    = 15;

  // Width of a station index; kept at least 1 so a 2-station build still has a bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vote_channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic            valid_o,
  output logic [ID_W-1:0] idx_o
);

  int cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_i) + k;
      if (cand >= N) cand = cand - N;
      if (!valid_o && req_i[ID_W'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vote_channel_arbiter.sv
// Shares one outbound 4-phase vote channel between stations, round-robin,
// acknowledging a station only after the tally receiver has accepted its vote.
module vote_channel_arbiter
  import vote_arb_pkg::*;
#(
  parameter  int N_STATIONS = DEF_N_STATIONS,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  localparam int ID_W       = id_w(N_STATIONS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_STATIONS-1:0]        st_rts,
  input  logic [N_STATIONS*DATA_W-1:0] st_data,
  output logic [N_STATIONS-1:0]        st_cts,
  output logic                         out_rtr,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ctr,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic [7:0]                   frames_done,
  output logic                         timeout_err,
  output logic [3:0]                   err_count
);

  arb_state_e              state_q, state_d;
  logic [ID_W-1:0]         last_q, last_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    rtr_q, rtr_d;
  logic [N_STATIONS-1:0]   cts_q, cts_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              frames_q, frames_d;
  logic                    terr_q, terr_d;
  logic [3:0]              errc_q, errc_d;

  logic                    pick_valid;
  logic [ID_W-1:0]         pick_idx;
  logic [DATA_W-1:0]       data_sel;

  rr_picker #(
    .N    (N_STATIONS),
    .ID_W (ID_W)
  ) u_picker (
    .req_i   (st_rts),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_STATIONS; i++) begin
      if (pick_idx == ID_W'(i)) data_sel = st_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    data_d   = data_q;
    rtr_d    = rtr_q;
    cts_d    = cts_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    terr_d   = 1'b0;
    errc_d   = errc_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          data_d  = data_sel;
          rtr_d   = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ctr) begin
          rtr_d   = 1'b0;
          state_d = REL_RX;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Abort: the station is never acknowledged and loses its turn.
          rtr_d   = 1'b0;
          terr_d  = 1'b1;
          if (errc_q != 4'hF) errc_d = errc_q + 4'd1;
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REL_RX: begin
        if (!out_ctr) begin
          cts_d   = N_STATIONS'(1) << grant_q;
          state_d = REL_ST;
        end
      end
      REL_ST: begin
        if (!st_rts[grant_q]) begin
          cts_d    = '0;
          frames_d = frames_q + 8'd1;
          last_d   = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= ID_W'(N_STATIONS - 1);
      grant_q  <= '0;
      data_q   <= '0;
      rtr_q    <= 1'b0;
      cts_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
      terr_q   <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      rtr_q    <= rtr_d;
      cts_q    <= cts_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      terr_q   <= terr_d;
      errc_q   <= errc_d;
    end
  end

  assign st_cts      = cts_q;
  assign out_rtr     = rtr_q;
  assign out_data    = data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign frames_done = frames_q;
  assign timeout_err = terr_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_vote_channel_arbiter.sv
// Directed self-checking bench for vote_channel_arbiter (4 stations, 4-bit votes, TIMEOUT=15).
module tb_vote_channel_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  st_rts;
  logic [15:0] st_data;
  logic [3:0]  st_cts;
  logic        out_rtr;
  logic [3:0]  out_data;
  logic        out_ctr;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  frames_done;
  logic        timeout_err;
  logic [3:0]  err_count;

  int errors = 0;
  int checks = 0;

  vote_channel_arbiter #(
    .N_STATIONS (4),
    .DATA_W     (4),
    .TIMEOUT    (15)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .st_rts      (st_rts),
    .st_data     (st_data),
    .st_cts      (st_cts),
    .out_rtr     (out_rtr),
    .out_data    (out_data),
    .out_ctr     (out_ctr),
    .grant_id    (grant_id),
    .busy        (busy),
    .frames_done (frames_done),
    .timeout_err (timeout_err),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic reset_dut();
    reset = 1'b1; st_rts = '0; st_data = '0; out_ctr = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; st_rts = '0; st_data = '0; out_ctr = 1'b0;
    step();
    checks++; if (st_cts !== 4'h0) begin errors++; $display("[TB] FAIL reset_cts: got %0h expected 0", st_cts); end
    checks++; if (out_rtr !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rtr_busy: got %b%b expected 00", out_rtr, busy); end
    checks++; if ({out_data, grant_id} !== 6'h0) begin errors++; $display("[TB] FAIL reset_data_id: got %0h/%0h expected 0/0", out_data, grant_id); end
    checks++; if ({frames_done, timeout_err, err_count} !== 13'h0) begin errors++; $display("[TB] FAIL reset_counters: got %0h/%b/%0h expected 0/0/0", frames_done, timeout_err, err_count); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    reset_dut();
    st_rts = 4'b0001; st_data = 16'h000A;
    step();
    checks++; if (out_rtr !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_grant_rtr: got rtr=%b busy=%b expected 1 1", out_rtr, busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL single_grant_id: got %0d expected 0", grant_id); end
    checks++; if (out_data !== 4'hA) begin errors++; $display("[TB] FAIL single_data: got %0h expected a", out_data); end
    step();
    checks++; if (out_rtr !== 1'b1) begin errors++; $display("[TB] FAIL single_rtr_hold: got %b expected 1", out_rtr); end
    out_ctr = 1'b1;
    step();
    checks++; if (out_rtr !== 1'b0 || st_cts !== 4'h0) begin errors++; $display("[TB] FAIL single_rtr_drop: got rtr=%b cts=%0h expected 0 0", out_rtr, st_cts); end
    out_ctr = 1'b0;
    step();
    checks++; if (st_cts !== 4'b0001) begin errors++; $display("[TB] FAIL single_cts_rise: got %b expected 0001", st_cts); end
    st_rts = 4'b0000;
    step();
    checks++; if (st_cts !== 4'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got cts=%0h busy=%b expected 0 0", st_cts, busy); end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("[TB] FAIL single_frames: got %0d expected 1", frames_done); end
  endtask

  task automatic test_round_robin();
    int expIds[5] = '{0, 1, 2, 3, 0};
    int nGrant = 0;
    int lastCyc = -1;
    logic prevRtr = 1'b0;
    reset_dut();
    st_data = 16'h3210; st_rts = 4'hF; out_ctr = 1'b0;
    for (int cyc = 0; cyc < 80 && nGrant < 5; cyc++) begin
      step();
      if (out_rtr && !prevRtr) begin
        checks++; if (grant_id !== 2'(expIds[nGrant])) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", nGrant, grant_id, expIds[nGrant]); end
        checks++; if (out_data !== 4'(expIds[nGrant])) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %0h expected %0h", nGrant, out_data, expIds[nGrant]); end
        if (nGrant > 0) begin
          checks++; if (cyc - lastCyc != 4) begin errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d cycles expected 4", nGrant, cyc - lastCyc); end
        end
        lastCyc = cyc;
        nGrant++;
      end
      prevRtr = out_rtr;
      out_ctr = out_rtr;
      st_rts  = 4'hF & ~st_cts;
    end
    checks++; if (nGrant != 5) begin errors++; $display("[TB] FAIL rr_budget: got %0d grants expected 5", nGrant); end
    st_rts = '0; out_ctr = 1'b0;
  endtask

  task automatic test_timeout();
    int hi = 0;
    int pulses = 0;
    logic ctsSeen = 1'b0;
    reset_dut();
    st_rts = 4'b0011; out_ctr = 1'b0;
    step();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL to_first_id: got %0d expected 0", grant_id); end
    while (out_rtr && hi < 40) begin
      hi++;
      step();
    end
    checks++; if (hi != 15) begin errors++; $display("[TB] FAIL to_rtr_len: got %0d cycles expected 15", hi); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_pulse: got %b expected 1", timeout_err); end
    checks++; if (err_count !== 4'd1) begin errors++; $display("[TB] FAIL to_errcount: got %0d expected 1", err_count); end
    checks++; if (st_cts !== 4'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_abort_state: got cts=%0h busy=%b expected 0 0", st_cts, busy); end
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width: got %b expected 0", timeout_err); end
    checks++; if (grant_id !== 2'd1 || out_rtr !== 1'b1) begin errors++; $display("[TB] FAIL to_next_grant: got id=%0d rtr=%b expected 1 1", grant_id, out_rtr); end
    st_rts = 4'hF;
    for (int cyc = 0; cyc < 19 * 16 + 40 && pulses < 19; cyc++) begin
      step();
      if (timeout_err) pulses++;
      if (st_cts != 4'h0) ctsSeen = 1'b1;
    end
    checks++; if (pulses != 19) begin errors++; $display("[TB] FAIL to_repeat: got %0d pulses expected 19", pulses); end
    checks++; if (err_count !== 4'd15) begin errors++; $display("[TB] FAIL to_saturate: got %0d expected 15", err_count); end
    checks++; if (ctsSeen !== 1'b0) begin errors++; $display("[TB] FAIL to_no_cts: got %b expected 0", ctsSeen); end
    st_rts = '0;
  endtask

  task automatic test_hold_data();
    reset_dut();
    st_rts = 4'b0100; st_data = 16'h0700;
    step();
    checks++; if (grant_id !== 2'd2 || out_data !== 4'h7) begin errors++; $display("[TB] FAIL hold_grant: got id=%0d data=%0h expected 2 7", grant_id, out_data); end
    st_rts = 4'b0000; st_data = 16'h0F00;
    step();
    checks++; if (out_rtr !== 1'b1 || out_data !== 4'h7) begin errors++; $display("[TB] FAIL hold_send: got rtr=%b data=%0h expected 1 7", out_rtr, out_data); end
    out_ctr = 1'b1;
    step();
    checks++; if (out_rtr !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_relrx: got rtr=%b busy=%b expected 0 1", out_rtr, busy); end
    out_ctr = 1'b0;
    step();
    checks++; if (st_cts !== 4'b0100) begin errors++; $display("[TB] FAIL hold_cts_rise: got %b expected 0100", st_cts); end
    step();
    checks++; if (st_cts !== 4'h0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_cts_fall: got cts=%b busy=%b expected 0000 0", st_cts, busy); end
    checks++; if (frames_done !== 8'd1 || out_data !== 4'h7) begin errors++; $display("[TB] FAIL hold_done: got frames=%0d data=%0h expected 1 7", frames_done, out_data); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    st_rts = 4'b0001; st_data = 16'h000C;
    step();
    out_ctr = 1'b1;
    step();
    checks++; if (busy !== 1'b1 || out_rtr !== 1'b0 || out_data !== 4'hC) begin errors++; $display("[TB] FAIL mid_relrx: got busy=%b rtr=%b data=%0h expected 1 0 c", busy, out_rtr, out_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({st_cts, out_rtr, out_data, grant_id, busy} !== 12'h0) begin errors++; $display("[TB] FAIL mid_async_out: got cts=%0h rtr=%b data=%0h id=%0d busy=%b expected all 0", st_cts, out_rtr, out_data, grant_id, busy); end
    checks++; if ({frames_done, timeout_err, err_count} !== 13'h0) begin errors++; $display("[TB] FAIL mid_async_cnt: got %0d/%b/%0d expected 0/0/0", frames_done, timeout_err, err_count); end
    out_ctr = 1'b0; st_rts = '0;
    step();
    reset = 1'b0; st_rts = 4'b1000; st_data = 16'h5000;
    step();
    checks++; if (grant_id !== 2'd3 || out_data !== 4'h5 || out_rtr !== 1'b1) begin errors++; $display("[TB] FAIL mid_regrant: got id=%0d data=%0h rtr=%b expected 3 5 1", grant_id, out_data, out_rtr); end
    st_rts = '0;
  endtask

  task automatic test_wrap();
    int done = 0;
    logic [3:0] prevCts = 4'h0;
    reset_dut();
    st_data = 16'h4321; st_rts = 4'hF; out_ctr = 1'b0;
    for (int cyc = 0; cyc < 1200 && done < 256; cyc++) begin
      step();
      if (prevCts != 4'h0 && st_cts == 4'h0) begin
        done++;
        if (done % 64 == 0 || done == 255) begin
          checks++; if (frames_done !== 8'(done)) begin errors++; $display("[TB] FAIL wrap_frames[%0d]: got %0d expected %0d", done, frames_done, done % 256); end
        end
      end
      prevCts = st_cts;
      out_ctr = out_rtr;
      st_rts  = 4'hF & ~st_cts;
    end
    checks++; if (done != 256) begin errors++; $display("[TB] FAIL wrap_budget: got %0d transfers expected 256", done); end
    checks++; if (err_count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_errcount: got %0d expected 0", err_count); end
    st_rts = '0; out_ctr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_hold_data();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vote_channel_arbiter.md
# vote_channel_arbiter

Sequencer and round-robin arbiter that shares one outbound vote channel between several voting stations. Each station offers a vote nibble through a 4-phase rts/cts handshake. The arbiter forwards one vote at a time to the tally receiver through a 4-phase rtr/ctr handshake and acknowledges the station only after the receiver has accepted. It sits between the per-station voting FSMs and the central tally, and supervises the receiver with a timeout.

## Interface
- N_STATIONS, 4, number of requesting stations (2..8)
- DATA_W, 4, vote word width
- TIMEOUT, 15, cycles allowed in SEND without out_ctr before abort (1..255)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; all state cleared on assertion
- st_rts  in  N_STATIONS  per-station request-to-send
- st_data  in  N_STATIONS*DATA_W  station i vote at [i*DATA_W +: DATA_W]
- st_cts  out  N_STATIONS  per-station clear-to-send (acknowledge), one-hot or zero
- out_rtr  out  1  request to tally receiver
- out_data  out  DATA_W  forwarded vote, stable while out_rtr=1
- out_ctr  in  1  receiver acknowledge
- grant_id  out  clog2(N_STATIONS)  station currently being served
- busy  out  1  high in any state other than IDLE
- frames_done  out  8  completed transfers, wraps 255->0
- timeout_err  out  1  one-cycle pulse on abort
- err_count  out  4  aborts, saturates at 15

## Operation
- All outputs registered. Reset values: st_cts=0, out_rtr=0, out_data=0, grant_id=0, busy=0, frames_done=0, timeout_err=0, err_count=0, state=IDLE, rr pointer last=N_STATIONS-1, so station 0 wins first.
- **IDLE:** if any st_rts is set, pick the first set bit searching last+1, last+2, … modulo N. Latch its data into out_data and its index into grant_id, set out_rtr=1, clear the timeout counter, and go to SEND.
- **SEND:** hold out_rtr and out_data.
  - If out_ctr=1: out_rtr←0, go to REL_RX.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: out_rtr←0, pulse timeout_err, err_count+1 (saturating), last←grant_id, go to IDLE. st_cts is never raised for an aborted station.
- **REL_RX:** wait for out_ctr=0, then st_cts[grant_id]←1 and go to REL_ST.
- **REL_ST:** wait for st_rts[grant_id]=0, then st_cts←0, frames_done+1, last←grant_id, go to IDLE.
- A station dropping st_rts during SEND or REL_RX is ignored; the latched data is still delivered.
- Changes on st_data after the grant are ignored.
- Requests arriving during a transfer wait; nothing is queued beyond the level of st_rts.
- A frames_done increment and a timeout abort never occur in the same cycle. They come from exclusive states.

## Timing
- From st_rts sampled high in IDLE at edge k: out_rtr, grant_id and out_data are valid after edge k.
- out_ctr high sampled at edge m: out_rtr is low after m.
- out_ctr low sampled at edge p: st_cts is high after p.
- st_rts low sampled at edge q: st_cts is low and frames_done is updated after q, and the state is IDLE.
- New arbitration happens at edge q+1 at the earliest. Minimum transfer is 4 cycles, with one dead IDLE cycle between grants.
- Timeout: abort at the TIMEOUT-th SEND cycle without out_ctr. With TIMEOUT=15, out_rtr is high for exactly 15 cycles.
- Reset asserted mid-transfer: all outputs drop asynchronously, no pulse is generated, and the pointer returns to N-1.

## Structure
- Package vote_arb_pkg holds:
  - the state enum (IDLE, SEND, REL_RX, REL_ST)
  - default parameter constants
  - the ID_W = clog2(N_STATIONS) helper function
- Sub-module rr_picker is purely combinational. Its inputs are the request vector and last; its outputs are valid and idx. The arbiter instantiates it once.

## Test plan
- Reset, then st_rts=0001, st_data[3:0]=4'hA; the receiver raises ctr 2 cycles after rtr and drops it 1 cycle after rtr falls. Expected: out_data=A, grant_id=0, st_cts[0] pulse, frames_done=1.
- st_rts=1111 held continuously, station i data=i, receiver acking immediately. Expected grant order 0,1,2,3,0, with out_data following the same sequence.
- Receiver never acks, TIMEOUT=15. Expected: out_rtr high for exactly 15 cycles, then timeout_err pulses once, err_count=1, st_cts stays 0 and the next grant goes to the following station. Repeat 20 times and check err_count holds at 15.
- Station 2 drops st_rts and changes st_data during SEND. Expected: the original word is delivered, and st_cts[2] rises then falls on the following cycle.
- Reset asserted during REL_RX. Expected: all outputs 0 immediately, and the next request from station 3 alone is granted.
- Run 256 completed transfers. Expected: frames_done wraps to 0.
